hazard_ctrl: RTL

//  Pipeline sequencer for the 16-bit 5-stage core. Drives the stall/flush controls
//  of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves:
//   - load-use hazards between ID and EX;
//   - branch/jump redirects from EX;
//   - structural conflicts when MEM uses the shared instruction RAM for a

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard sequencer and the 5-stage datapath.
// The master side supplies ID/EX/MEM hazard sources; the slave side returns register controls.
interface hazard_ctrl_if;
    logic [2:0]  idRx;
    logic [2:0]  idRy;
    logic        idUseRx;
    logic        idUseRy;
    logic [1:0]  exMemRead;
    logic        exRegWrite;
    logic [2:0]  exRd;
    logic        exRedirect;
    logic        memSharedAcc;
    logic        statClr;

    logic        pcStall;
    logic        ifIdStall;
    logic        ifIdFlush;
    logic        idExStall;
    logic        idExFlush;
    logic        exMemStall;
    logic        memWbFlush;
    logic        busy;
    logic [15:0] stallCount;

    modport master (
        output idRx, idRy, idUseRx, idUseRy, exMemRead, exRegWrite, exRd,
               exRedirect, memSharedAcc, statClr,
        input  pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush,
               exMemStall, memWbFlush, busy, stallCount
    );

    modport slave (
        input  idRx, idRy, idUseRx, idUseRy, exMemRead, exRegWrite, exRd,
               exRedirect, memSharedAcc, statClr,
        output pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush,
               exMemStall, memWbFlush, busy, stallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit 5-stage core: load-use, EX redirects and
// shared instruction-RAM conflicts from multi-cycle MEM accesses.
module hazard_ctrl #(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int CW = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;

    state_t      state;
    logic [CW-1:0] wait_cnt;
    logic [15:0] stall_cnt;

    logic load_use;
    logic trigger;
    logic last_cyc;
    logic hold_cyc;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;

    assign load_use = (bus.exMemRead != 2'b00) && bus.exRegWrite &&
                      ((bus.idUseRx && (bus.idRx == bus.exRd)) ||
                       (bus.idUseRy && (bus.idRy == bus.exRd)));

    assign trigger  = (state == RUN) && bus.memSharedAcc;

    // The Last cycle of a shared access is the one where the fetch slot is lost
    // but EX is no longer frozen, so redirect/load-use are honoured again.
    assign last_cyc = (trigger && (MEM_WAIT_CYCLES == 1)) ||
                      ((state == MEM_WAIT) && (wait_cnt == CW'(1)));
    assign hold_cyc = (trigger && (MEM_WAIT_CYCLES > 1)) ||
                      ((state == MEM_WAIT) && (wait_cnt != CW'(1)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!RST) begin
            pc_stall = 1'b0;
        end else if (hold_cyc) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (bus.exRedirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (last_cyc) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.memSharedAcc && (MEM_WAIT_CYCLES > 1)) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CW'(MEM_WAIT_CYCLES - 1);
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_cnt == CW'(1)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if (bus.statClr) begin
                stall_cnt <= '0;
            end else if (pc_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign bus.pcStall    = pc_stall;
    assign bus.ifIdStall  = if_id_stall;
    assign bus.ifIdFlush  = if_id_flush;
    assign bus.idExStall  = id_ex_stall;
    assign bus.idExFlush  = id_ex_flush;
    assign bus.exMemStall = ex_mem_stall;
    assign bus.memWbFlush = mem_wb_flush;
    assign bus.busy       = (state == MEM_WAIT);
    assign bus.stallCount = stall_cnt;
endmodule
